// File: rtl/maple_frame_receiver_if.sv
// rtl/maple_frame_receiver_if.sv - byte input, header/status and word stream signals of the Maple frame receiver
interface maple_frame_receiver_if;
    logic        frame_active;
    logic [7:0]  byte_data;
    logic        byte_ready;

    logic [7:0]  hdr_cmd;
    logic [7:0]  hdr_dest;
    logic [7:0]  hdr_src;
    logic [7:0]  hdr_len;
    logic        hdr_valid;

    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;

    logic        frame_done;
    logic        crc_ok;
    logic        err_short;
    logic        err_long;
    logic        err_ovf;

    // Environment side: drives bytes and consumes words.
    modport master (
        output frame_active, byte_data, byte_ready, word_ready,
        input  hdr_cmd, hdr_dest, hdr_src, hdr_len, hdr_valid,
        input  word_data, word_valid,
        input  frame_done, crc_ok, err_short, err_long, err_ovf
    );

    // Receiver side.
    modport slave (
        input  frame_active, byte_data, byte_ready, word_ready,
        output hdr_cmd, hdr_dest, hdr_src, hdr_len, hdr_valid,
        output word_data, word_valid,
        output frame_done, crc_ok, err_short, err_long, err_ovf
    );
endinterface

// File: rtl/maple_frame_receiver.sv
// rtl/maple_frame_receiver.sv - Maple bus frame receiver: header decode, payload word FIFO, XOR check
// FIFO_DEPTH must be a power of two and at least 2.
module maple_frame_receiver #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    maple_frame_receiver_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_CRC,
        S_WAIT_END,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [9:0]   byte_cnt_q, byte_cnt_d;
    logic [9:0]   exp_cnt_q, exp_cnt_d;
    logic [7:0]   crc_q, crc_d;
    logic [23:0]  word_acc_q, word_acc_d;
    logic [7:0]   hdr_cmd_q, hdr_cmd_d;
    logic [7:0]   hdr_dest_q, hdr_dest_d;
    logic [7:0]   hdr_src_q, hdr_src_d;
    logic [7:0]   hdr_len_q, hdr_len_d;
    logic         hdr_valid_q, hdr_valid_d;
    logic         frame_done_q, frame_done_d;
    logic         crc_ok_q, crc_ok_d;
    logic         err_short_q, err_short_d;
    logic         err_long_q, err_long_d;
    logic         err_ovf_q, err_ovf_d;
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0]  mem_q [FIFO_DEPTH];

    logic [CNT_W-1:0] fifo_count;
    logic         fifo_empty;
    logic         fifo_full;
    logic         pop;
    logic         push;
    logic         wr_en;
    logic [31:0]  push_word;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && bus.word_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en      = push && (!fifo_full || pop);

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        exp_cnt_d    = exp_cnt_q;
        crc_d        = crc_q;
        word_acc_d   = word_acc_q;
        hdr_cmd_d    = hdr_cmd_q;
        hdr_dest_d   = hdr_dest_q;
        hdr_src_d    = hdr_src_q;
        hdr_len_d    = hdr_len_q;
        hdr_valid_d  = hdr_valid_q;
        crc_ok_d     = crc_ok_q;
        err_short_d  = err_short_q;
        err_long_d   = err_long_q;
        err_ovf_d    = err_ovf_q;
        push         = 1'b0;
        push_word    = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.frame_active) begin
                    state_d     = S_HEADER;
                    byte_cnt_d  = '0;
                    crc_d       = '0;
                    hdr_valid_d = 1'b0;
                    crc_ok_d    = 1'b0;
                    err_short_d = 1'b0;
                    err_long_d  = 1'b0;
                    err_ovf_d   = 1'b0;
                end
            end
            S_HEADER: begin
                if (bus.byte_ready) begin
                    crc_d      = crc_q ^ bus.byte_data;
                    byte_cnt_d = byte_cnt_q + 10'd1;
                    case (byte_cnt_q[1:0])
                        2'd0: hdr_cmd_d  = bus.byte_data;
                        2'd1: hdr_dest_d = bus.byte_data;
                        2'd2: hdr_src_d  = bus.byte_data;
                        default: begin
                            hdr_len_d   = bus.byte_data;
                            hdr_valid_d = 1'b1;
                            byte_cnt_d  = '0;
                            exp_cnt_d   = {bus.byte_data, 2'b00};
                            state_d     = (bus.byte_data == 8'd0) ? S_CRC : S_PAYLOAD;
                        end
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (bus.byte_ready) begin
                    crc_d      = crc_q ^ bus.byte_data;
                    byte_cnt_d = byte_cnt_q + 10'd1;
                    word_acc_d = {word_acc_q[15:0], bus.byte_data};
                    if (byte_cnt_q[1:0] == 2'd3) begin
                        push      = 1'b1;
                        push_word = {word_acc_q, bus.byte_data};
                    end
                    if (byte_cnt_q == exp_cnt_q - 10'd1) begin
                        state_d = S_CRC;
                    end
                end
            end
            S_CRC: begin
                if (bus.byte_ready) begin
                    crc_ok_d = (bus.byte_data == crc_q);
                    state_d  = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (bus.byte_ready) begin
                    err_long_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // End-of-frame check looks at the state after any byte of this cycle.
        if (!bus.frame_active) begin
            case (state_d)
                S_HEADER, S_PAYLOAD, S_CRC: begin
                    err_short_d = 1'b1;
                    crc_ok_d    = 1'b0;
                    state_d     = S_DONE;
                end
                S_WAIT_END: state_d = S_DONE;
                default: ;
            endcase
        end

        if (push && fifo_full && !pop) begin
            err_ovf_d = 1'b1;
        end

        frame_done_d = (state_d == S_DONE);
        wr_ptr_d     = wr_ptr_q + CNT_W'(wr_en);
        rd_ptr_d     = rd_ptr_q + CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            exp_cnt_q    <= '0;
            crc_q        <= '0;
            word_acc_q   <= '0;
            hdr_cmd_q    <= '0;
            hdr_dest_q   <= '0;
            hdr_src_q    <= '0;
            hdr_len_q    <= '0;
            hdr_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            crc_ok_q     <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            exp_cnt_q    <= exp_cnt_d;
            crc_q        <= crc_d;
            word_acc_q   <= word_acc_d;
            hdr_cmd_q    <= hdr_cmd_d;
            hdr_dest_q   <= hdr_dest_d;
            hdr_src_q    <= hdr_src_d;
            hdr_len_q    <= hdr_len_d;
            hdr_valid_q  <= hdr_valid_d;
            frame_done_q <= frame_done_d;
            crc_ok_q     <= crc_ok_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            err_ovf_q    <= err_ovf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Storage is never reset; the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_word;
        end
    end

    assign bus.hdr_cmd    = hdr_cmd_q;
    assign bus.hdr_dest   = hdr_dest_q;
    assign bus.hdr_src    = hdr_src_q;
    assign bus.hdr_len    = hdr_len_q;
    assign bus.hdr_valid  = hdr_valid_q;
    assign bus.word_valid = !fifo_empty;
    assign bus.word_data  = fifo_empty ? 32'd0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.frame_done = frame_done_q;
    assign bus.crc_ok     = crc_ok_q;
    assign bus.err_short  = err_short_q;
    assign bus.err_long   = err_long_q;
    assign bus.err_ovf    = err_ovf_q;
endmodule
